// File: rtl/scr_stack_ctrl.sv
// rtl/scr_stack_ctrl.sv - scratch RAM memory/stack operation sequencer
// Two-cycle IDLE/ACCESS handshake; owns the stack pointer, depth and sticky error.
module scr_stack_ctrl #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 10,
  parameter logic [ADDR_W-1:0] SP_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              OP_VALID,
  output logic              OP_READY,
  input  logic [2:0]        OP_CODE,
  input  logic [ADDR_W-1:0] OP_ADDR,
  input  logic [DATA_W-1:0] REG_DATA,
  input  logic [DATA_W-1:0] PC_DATA,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DATA_IN,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              RD_PC,
  output logic [ADDR_W-1:0] SP,
  output logic [ADDR_W:0]   DEPTH,
  output logic              STK_ERR
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [2:0] OP_STORE = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_WSP   = 3'd6;
  localparam logic [2:0] OP_RSP   = 3'd7;

  localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_next_state;
  logic              w_ready;
  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic [2:0]        r_op;
  logic              r_uflow;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W:0]   r_depth;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_we;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_pc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (OP_VALID) w_next_state = S_ACCESS;
      end
      S_ACCESS: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign w_accept = OP_VALID & w_ready;
  assign w_full   = (r_depth == DEPTH_MAX);
  assign w_empty  = (r_depth == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op       <= OP_STORE;
      r_uflow    <= 1'b0;
      r_sp       <= SP_INIT;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pc    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= 1'b0;
      if (w_accept) begin
        r_op    <= OP_CODE;
        r_uflow <= 1'b0;
        r_we    <= 1'b0;
        case (OP_CODE)
          OP_STORE: begin
            r_addr <= OP_ADDR;
            r_din  <= REG_DATA;
            r_we   <= 1'b1;
          end
          OP_LOAD: r_addr <= OP_ADDR;
          OP_PUSH, OP_CALL: begin
            r_addr <= r_sp - 1'b1;
            r_din  <= (OP_CODE == OP_CALL) ? PC_DATA : REG_DATA;
            if (w_full) begin
              r_err <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_sp    <= r_sp - 1'b1;
              r_depth <= r_depth + 1'b1;
            end
          end
          OP_POP, OP_RET: begin
            r_addr <= r_sp;
            if (w_empty) begin
              r_uflow <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_sp    <= r_sp + 1'b1;
              r_depth <= r_depth - 1'b1;
            end
          end
          OP_WSP: begin
            r_sp    <= OP_ADDR;
            r_depth <= '0;
            r_err   <= 1'b0;
          end
          default: ;
        endcase
      end else if (r_state == S_ACCESS) begin
        r_we <= 1'b0;
        // RSP leaves SP untouched, so r_sp here is still the pre-op value
        case (r_op)
          OP_LOAD: begin
            r_rd_data  <= SCR_DATA_OUT;
            r_rd_valid <= 1'b1;
          end
          OP_POP, OP_RET: begin
            r_rd_data  <= r_uflow ? '0 : SCR_DATA_OUT;
            r_rd_valid <= 1'b1;
            r_rd_pc    <= (r_op == OP_RET);
          end
          OP_RSP: begin
            r_rd_data  <= DATA_W'(r_sp);
            r_rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign OP_READY    = w_ready;
  assign SCR_ADDR    = r_addr;
  assign SCR_DATA_IN = r_din;
  assign SCR_WE      = r_we;
  assign RD_DATA     = r_rd_data;
  assign RD_VALID    = r_rd_valid;
  assign RD_PC       = r_rd_pc;
  assign SP          = r_sp;
  assign DEPTH       = r_depth;
  assign STK_ERR     = r_err;

endmodule

// File: doc/scr_stack_ctrl.md
Name: scr_stack_ctrl

Overview:
Sequencer that sits directly upstream of the MCU scratch RAM (256 x 10-bit, async read, sync write). It accepts one memory/stack operation at a time from the control unit and owns the stack pointer. It drives the RAM address, write data and write enable, then returns read data (LOAD/POP/RET/RSP) with a valid pulse. It also tracks stack depth and flags overflow and underflow.

Parameters:
ADDR_W, 8, scratch address width; RAM depth = 2**ADDR_W
DATA_W, 10, scratch data width
SP_INIT, 0, stack pointer value after reset and the empty-stack top

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
OP_VALID  in  1  operation request
OP_READY  out  1  block can accept; transfer when OP_VALID & OP_READY
OP_CODE  in  3  0 STORE, 1 LOAD, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 WSP, 7 RSP
OP_ADDR  in  ADDR_W  direct address (STORE/LOAD); new SP value (WSP)
REG_DATA  in  DATA_W  write data for STORE/PUSH
PC_DATA  in  DATA_W  return address for CALL
SCR_DATA_OUT  in  DATA_W  async read data from scratch RAM
SCR_ADDR  out  ADDR_W  registered RAM address
SCR_DATA_IN  out  DATA_W  registered RAM write data
SCR_WE  out  1  registered RAM write enable
RD_DATA  out  DATA_W  returned read data
RD_VALID  out  1  one-cycle pulse, RD_DATA valid
RD_PC  out  1  qualifies RD_VALID: data is a return address (RET)
SP  out  ADDR_W  current stack pointer
DEPTH  out  ADDR_W+1  entries on stack, 0..256
STK_ERR  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async): FSM=IDLE; SP=SP_INIT; DEPTH=0; STK_ERR=0; SCR_ADDR=0, SCR_DATA_IN=0, SCR_WE=0; RD_DATA=0, RD_VALID=0, RD_PC=0. A write in flight is aborted because SCR_WE drops immediately.
- FSM states: IDLE (OP_READY=1) and ACCESS (OP_READY=0). Accept in IDLE -> ACCESS; ACCESS -> IDLE unconditionally. Each op takes 2 cycles; max throughput is 1 op per 2 cycles. OP_VALID during ACCESS is ignored.
- On the accept edge, SCR_ADDR/SCR_DATA_IN/SCR_WE are loaded per op and held for the ACCESS cycle. SCR_WE is high only in ACCESS and returns to 0 on the ACCESS->IDLE edge.
  - STORE: addr=OP_ADDR, data=REG_DATA, WE=1.
  - LOAD: addr=OP_ADDR, WE=0.
  - PUSH/CALL: addr=SP-1 (mod 256), data=REG_DATA or PC_DATA, WE=1; SP<=SP-1; DEPTH+1.
  - POP/RET: addr=SP, WE=0; SP<=SP+1 (mod 256); DEPTH-1.
  - WSP: SP<=OP_ADDR; DEPTH<=0; STK_ERR<=0; no RAM access (WE=0).
  - RSP: no RAM access; returns zero-extended SP (value before this op).
- Read return: at the ACCESS->IDLE edge, LOAD/POP/RET capture SCR_DATA_OUT into RD_DATA and RSP captures SP. RD_VALID pulses high for exactly the following cycle. Latency is accept edge + 2 cycles to RD_VALID. RD_PC=1 only with a RET return. RD_DATA holds its value until the next return.
- Overflow: PUSH/CALL with DEPTH==256 -> WE=0, SP/DEPTH unchanged, STK_ERR<=1. The op still occupies 2 cycles.
- Underflow: POP/RET with DEPTH==0 -> no SP/DEPTH change, RD_DATA=0, RD_VALID still pulses (RD_PC set for RET), STK_ERR<=1.
- STK_ERR clears only on RST or WSP.
- SP wraps modulo 256; DEPTH saturates by the overflow/underflow rules above and never wraps.

Test Plan:
- Reset then STORE addr 0x12 data 0x2A5, then LOAD 0x12 -> SCR_WE=1 for exactly 1 cycle at addr 0x12; RD_DATA=0x2A5 with RD_VALID 2 cycles after the LOAD accept; OP_READY low during each ACCESS.
- From SP=0: PUSH 0x001, PUSH 0x002, POP, POP -> writes at 0xFF then 0xFE; SP 0xFF, 0xFE, 0xFF, 0x00; returns 0x002 then 0x001; DEPTH 1, 2, 1, 0; STK_ERR=0.
- CALL with PC_DATA=0x3C4 then RET -> RAM[0xFF]=0x3C4; RD_DATA=0x3C4 with RD_PC=1; SP back to 0.
- POP on an empty stack -> RD_VALID with RD_DATA=0, STK_ERR=1, SP=0; then WSP 0x80 -> SP=0x80, DEPTH=0, STK_ERR=0; RSP returns 0x080.
- 256 PUSHes then a 257th -> 257th has no write, SP=0x00, DEPTH=256, STK_ERR=1.
- Assert RST during the ACCESS cycle of a STORE -> SCR_WE falls immediately, target RAM word unchanged, all outputs at reset values, OP_READY=1 after release.
